uart_rx_param: RTL and testbench

Parametrised UART receiver and successor to `uart_rx_module`. It adds configurable clocks-per-bit, data width, parity and stop bits, a synchronous reset, metastability synchronisation, 3-sample majority voting, false-start rejection, and parity/framing error reporting. It sits between an asynchronous serial line and the on-chip command parser, which consumes one word per `data_flag` pulse.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx_param.sv | 140 ++++++++++++++
 tb/tb_uart_rx_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the parametrised UART receiver and the future transmitter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser on the serial line followed by a 3-sample majority voter.
module uart_rx_sampler (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_sync,
   output logic vote
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic [1:0] hist_q, hist_d;

   always_comb begin
      sync1_d = line_in;
      sync2_d = sync1_q;
      hist_d  = {hist_q[0], sync2_q};
   end

   // Everything resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         hist_q  <= 2'b11;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         hist_q  <= hist_d;
      end
   end

   assign line_sync = sync2_q;
   assign vote      = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit majority sampling, optional parity,
// one or two stop bits, false-start rejection and break handling.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_line,
   output logic                 data_flag,
   output logic [DATA_BITS-1:0] data_byte,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CNT_W = clog2(CLKS_PER_BIT);
   localparam int IDX_W = clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 flag_q, flag_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic                 par_err_q, par_err_d;
   logic                 frm_err_q, frm_err_d;
   logic                 line_sync, vote, bit_end, exp_par;

   uart_rx_sampler u_sampler (
      .clk       (clk),
      .rst       (rst),
      .line_in   (data_line),
      .line_sync (line_sync),
      .vote      (vote)
   );

   assign bit_end = (cnt_q == LAST_CNT);
   assign exp_par = (PARITY == PAR_EVEN) ? ^shreg_q : ~^shreg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         flag_q    <= 1'b0;
         byte_q    <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         flag_q    <= flag_d;
         byte_q    <= byte_d;
         par_err_q <= par_err_d;
         frm_err_q <= frm_err_d;
      end
   end

   // Only presented through byte_q, so the shifter needs no reset.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!line_sync) state_d = ST_START;
         ST_START: if (cnt_q == HALF_CNT) state_d = vote ? ST_IDLE : ST_DATA;
         ST_DATA:  if (bit_end && idx_q == LAST_DATA)
                      state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
         ST_PAR:   if (bit_end) state_d = ST_STOP;
         ST_STOP:  if (bit_end && idx_q == LAST_STOP) state_d = vote ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (line_sync) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      flag_d    = 1'b0;
      byte_d    = byte_q;
      par_err_d = par_err_q;
      frm_err_d = frm_err_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            idx_d  = '0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
         end
         ST_START: if (cnt_q == HALF_CNT) cnt_d = '0;
         ST_DATA: if (bit_end) begin
            shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
            idx_d   = (idx_q == LAST_DATA) ? '0 : idx_q + IDX_W'(1);
         end
         ST_PAR: if (bit_end && vote != exp_par) perr_d = 1'b1;
         ST_STOP: if (bit_end) begin
            idx_d = idx_q + IDX_W'(1);
            if (!vote) ferr_d = 1'b1;
            // Errored frames are still presented; the consumer decides.
            if (idx_q == LAST_STOP) begin
               flag_d    = 1'b1;
               byte_d    = shreg_q;
               par_err_d = perr_q;
               frm_err_d = ferr_q | ~vote;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      data_flag  = flag_q;
      data_byte  = byte_q;
      parity_err = par_err_q;
      frame_err  = frm_err_q;
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (default, even parity,
// 7 data bits with 2 stop bits) driven from a frame table plus corner sequences.
module tb_uart_rx_param;

   localparam int CPB  = 8;
   localparam int HALF = CPB / 2;

   typedef struct packed {
      logic [8:0] b;
      logic       pe;
      logic       fe;
   } exp_t;

   typedef struct {
      int         dut;
      logic [8:0] data;
      logic       pbit;
      logic       stop_last;
      int         gap;
      logic [8:0] exp_b;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       line0, line1, line2;
   logic       flag0, flag1, flag2;
   logic [7:0] dbyte0, dbyte1;
   logic [6:0] dbyte2;
   logic       perr0, perr1, perr2;
   logic       ferr0, ferr1, ferr2;
   logic       busy0, busy1, busy2;

   int   total = 0;
   int   passed = 0;
   int   cyc = 0;
   int   first_flag_cyc = -1;
   int   flag_cnt [3];
   logic prev_f [3];
   exp_t q_def[$];
   exp_t q_par[$];
   exp_t q_7b[$];
   vec_t vecs [12];

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_def (
      .clk(clk), .rst(rst), .data_line(line0), .data_flag(flag0), .data_byte(dbyte0),
      .parity_err(perr0), .frame_err(ferr0), .busy(busy0));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_par (
      .clk(clk), .rst(rst), .data_line(line1), .data_flag(flag1), .data_byte(dbyte1),
      .parity_err(perr1), .frame_err(ferr1), .busy(busy1));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7b (
      .clk(clk), .rst(rst), .data_line(line2), .data_flag(flag2), .data_byte(dbyte2),
      .parity_err(perr2), .frame_err(ferr2), .busy(busy2));

   always #50 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
      else passed++;
   endtask

   function automatic int db(input int d);
      return (d == 2) ? 7 : 8;
   endfunction

   function automatic int sb(input int d);
      return (d == 2) ? 2 : 1;
   endfunction

   task automatic push_exp(input int d, input logic [8:0] b, input logic pe, input logic fe);
      exp_t e;
      e = {b, pe, fe};
      case (d)
         0:       q_def.push_back(e);
         1:       q_par.push_back(e);
         default: q_7b.push_back(e);
      endcase
   endtask

   task automatic drive_bit(input int d, input logic v);
      case (d)
         0:       line0 = v;
         1:       line1 = v;
         default: line2 = v;
      endcase
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                             input logic stop_last);
      drive_bit(d, 1'b0);
      for (int i = 0; i < db(d); i++) drive_bit(d, data[i]);
      if (d == 1) drive_bit(d, pbit);
      for (int s = 0; s < sb(d); s++) drive_bit(d, (s == sb(d) - 1) ? stop_last : 1'b1);
   endtask

   // Scoreboard: every flag must match the oldest expected frame of that receiver.
   task automatic mon(input int d, input logic f, input logic [8:0] b, input logic pe,
                      input logic fe);
      exp_t e;
      logic have;
      if (!f) begin
         prev_f[d] = 1'b0;
         return;
      end
      have = 1'b0;
      e    = '0;
      case (d)
         0: if (q_def.size() != 0) begin e = q_def.pop_front(); have = 1'b1; end
         1: if (q_par.size() != 0) begin e = q_par.pop_front(); have = 1'b1; end
         default: if (q_7b.size() != 0) begin e = q_7b.pop_front(); have = 1'b1; end
      endcase
      flag_cnt[d]++;
      if (d == 0 && first_flag_cyc < 0) first_flag_cyc = cyc;
      check($sformatf("flag_single_cycle dut%0d", d), {31'd0, prev_f[d]}, 32'd0);
      prev_f[d] = 1'b1;
      if (!have) begin
         total++;
         $display("FAIL unexpected_flag dut%0d: got flag with data_byte %0h, required no flag", d, b);
      end else begin
         check($sformatf("data_byte dut%0d", d), {23'd0, b}, {23'd0, e.b});
         check($sformatf("parity_err dut%0d", d), {31'd0, pe}, {31'd0, e.pe});
         check($sformatf("frame_err dut%0d", d), {31'd0, fe}, {31'd0, e.fe});
      end
   endtask

   always @(negedge clk) begin
      mon(0, flag0, {1'b0, dbyte0}, perr0, ferr0);
      mon(1, flag1, {1'b0, dbyte1}, perr1, ferr1);
      mon(2, flag2, {2'b0, dbyte2}, perr2, ferr2);
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got no end of test, required finish within 20000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start_cyc;
      int base;

      for (int i = 0; i < 3; i++) begin
         flag_cnt[i] = 0;
         prev_f[i]   = 1'b0;
      end
      // {dut, data, parity bit, last stop bit, idle bits after, expected byte, perr, ferr}
      vecs[0]  = '{0, 9'h055, 1'b0, 1'b1, 0, 9'h055, 1'b0, 1'b0};
      vecs[1]  = '{0, 9'h055, 1'b0, 1'b1, 0, 9'h055, 1'b0, 1'b0};
      vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 0, 9'h0FF, 1'b0, 1'b0};
      vecs[3]  = '{0, 9'h000, 1'b0, 1'b1, 2, 9'h000, 1'b0, 1'b0};
      vecs[4]  = '{0, 9'h080, 1'b0, 1'b1, 2, 9'h080, 1'b0, 1'b0};
      vecs[5]  = '{1, 9'h0A5, 1'b0, 1'b1, 1, 9'h0A5, 1'b0, 1'b0};
      vecs[6]  = '{1, 9'h0A5, 1'b1, 1'b1, 1, 9'h0A5, 1'b1, 1'b0};
      vecs[7]  = '{1, 9'h03C, 1'b0, 1'b1, 1, 9'h03C, 1'b0, 1'b0};
      vecs[8]  = '{1, 9'h001, 1'b1, 1'b1, 1, 9'h001, 1'b0, 1'b0};
      vecs[9]  = '{2, 9'h055, 1'b0, 1'b1, 1, 9'h055, 1'b0, 1'b0};
      vecs[10] = '{2, 9'h02A, 1'b0, 1'b0, 1, 9'h02A, 1'b0, 1'b1};
      vecs[11] = '{2, 9'h07F, 1'b0, 1'b1, 1, 9'h07F, 1'b0, 1'b0};

      line0 = 1'b1;
      line1 = 1'b1;
      line2 = 1'b1;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset outputs dut0", {20'd0, flag0, dbyte0, perr0, ferr0, busy0}, 32'd0);
      check("reset outputs dut1", {20'd0, flag1, dbyte1, perr1, ferr1, busy1}, 32'd0);
      check("reset outputs dut2", {21'd0, flag2, dbyte2, perr2, ferr2, busy2}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      start_cyc = cyc;
      for (int i = 0; i < 12; i++) begin
         push_exp(vecs[i].dut, vecs[i].exp_b, vecs[i].exp_pe, vecs[i].exp_fe);
         send_frame(vecs[i].dut, vecs[i].data, vecs[i].pbit, vecs[i].stop_last);
         for (int g = 0; g < vecs[i].gap; g++) drive_bit(vecs[i].dut, 1'b1);
      end
      repeat (CPB) @(negedge clk);
      // One negedge from drive to first sampling edge, then the documented latency.
      check("first frame latency", first_flag_cyc - start_cyc,
            1 + (2 + HALF + (8 + 0 + 1) * CPB + 1));
      check("table flag count dut0", flag_cnt[0], 5);
      check("table flag count dut1", flag_cnt[1], 4);
      check("table flag count dut2", flag_cnt[2], 3);

      // False start: two-cycle low glitch on an idle line.
      base  = flag_cnt[0];
      line0 = 1'b0;
      repeat (2) @(negedge clk);
      line0 = 1'b1;
      repeat (3) @(negedge clk);
      check("false start busy raised", {31'd0, busy0}, 32'd1);
      repeat (HALF + 3 - 3) @(negedge clk);
      check("false start busy dropped", {31'd0, busy0}, 32'd0);
      repeat (2 * CPB * 10) @(negedge clk);
      check("false start no flag", flag_cnt[0] - base, 0);

      // Framing error, then the line held low for 40 bit times.
      base = flag_cnt[0];
      push_exp(0, 9'h081, 1'b0, 1'b1);
      send_frame(0, 9'h081, 1'b0, 1'b0);
      repeat (40 * CPB) @(negedge clk);
      check("break single flag", flag_cnt[0] - base, 1);
      check("break busy held", {31'd0, busy0}, 32'd1);
      line0 = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("break released", {31'd0, busy0}, 32'd0);
      push_exp(0, 9'h0C3, 1'b0, 1'b0);
      send_frame(0, 9'h0C3, 1'b0, 1'b1);
      repeat (CPB) @(negedge clk);
      check("frame after break", flag_cnt[0] - base, 2);

      // One-cycle high spike at the middle of data bit 3 of 0x00.
      base = flag_cnt[0];
      push_exp(0, 9'h000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
      line0 = 1'b0;
      repeat (5) @(negedge clk);
      line0 = 1'b1;
      @(negedge clk);
      line0 = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      repeat (CPB) @(negedge clk);
      check("glitch frame flag", flag_cnt[0] - base, 1);

      // Reset during data bit 4 of a 7-bit frame; the sender then abandons it.
      base = flag_cnt[2];
      for (int i = 0; i < 5; i++) drive_bit(2, (i == 0) ? 1'b0 : ((i % 2) == 1));
      line2 = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      line2 = 1'b1;
      check("midframe reset busy", {31'd0, busy2}, 32'd0);
      check("midframe reset flag", {31'd0, flag2}, 32'd0);
      check("midframe reset data_byte", {25'd0, dbyte2}, 32'd0);
      check("midframe reset errors", {30'd0, perr2, ferr2}, 32'd0);
      repeat (24 * CPB) @(negedge clk);
      check("midframe reset no flag", flag_cnt[2] - base, 0);
      push_exp(2, 9'h03C, 1'b0, 1'b0);
      send_frame(2, 9'h03C, 1'b0, 1'b1);
      repeat (CPB) @(negedge clk);
      check("frame after reset", flag_cnt[2] - base, 1);

      check("pending frames dut0", q_def.size(), 0);
      check("pending frames dut1", q_par.size(), 0);
      check("pending frames dut2", q_7b.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
